// File: rtl/sram_decode_sequencer_pkg.sv
// sram_seq_pkg: phase encoding, requester indices and default timeouts for the decode sequencer
package sram_seq_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      UART_INIT = 3'd1,
      UART_RX   = 3'd2,
      M2_RUN    = 3'd3,
      M2_DRAIN  = 3'd4,
      M1_RUN    = 3'd5,
      M1_DRAIN  = 3'd6
   } phase_t;

   localparam logic [2:0] REQ_VGA  = 3'd0;
   localparam logic [2:0] REQ_UART = 3'd1;
   localparam logic [2:0] REQ_M2   = 3'd2;
   localparam logic [2:0] REQ_M1   = 3'd3;
   localparam logic [2:0] REQ_NONE = 3'd4;

   localparam int UART_TIMEOUT_DEF  = 50_000_000;
   localparam int STAGE_TIMEOUT_DEF = 67_108_863;
   localparam int TMR_W_DEF         = 26;

   // owner of the SRAM port in each phase; the drain phases keep the stage's grant
   function automatic logic [2:0] req_of(input phase_t p);
      case (p)
         IDLE:                return REQ_VGA;
         UART_INIT, UART_RX:  return REQ_UART;
         M2_RUN, M2_DRAIN:    return REQ_M2;
         M1_RUN, M1_DRAIN:    return REQ_M1;
         default:             return REQ_NONE;
      endcase
   endfunction

endpackage

// File: rtl/sram_port_mux.sv
// sram_port_mux: combinational 4-way SRAM port select driven purely by the sequencer phase
module sram_port_mux
   import sram_seq_pkg::*;
#(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 16
)(
   input  phase_t              phase,
   input  logic [ADDR_W-1:0]   vga_addr,
   input  logic [ADDR_W-1:0]   uart_addr,
   input  logic [DATA_W-1:0]   uart_wdata,
   input  logic                uart_we_n,
   input  logic [ADDR_W-1:0]   m2_addr,
   input  logic [DATA_W-1:0]   m2_wdata,
   input  logic                m2_we_n,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic                m1_we_n,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic [DATA_W-1:0]   sram_wdata,
   output logic                sram_we_n
);

   logic [2:0] req;

   // VGA only reads; an undefined phase parks the port with writes disabled
   always_comb begin
      req        = req_of(phase);
      sram_addr  = req == REQ_UART ? uart_addr  : req == REQ_M2 ? m2_addr  : req == REQ_M1 ? m1_addr  : req == REQ_VGA ? vga_addr : '0;
      sram_wdata = req == REQ_UART ? uart_wdata : req == REQ_M2 ? m2_wdata : req == REQ_M1 ? m1_wdata : '0;
      sram_we_n  = req == REQ_UART ? uart_we_n  : req == REQ_M2 ? m2_we_n  : req == REQ_M1 ? m1_we_n  : 1'b1;
   end

endmodule

// File: rtl/sram_decode_sequencer.sv
// sram_decode_sequencer: UART load -> M2 -> M1 -> VGA flow sequencer owning the SRAM port
// Optional: define STAGE_CYCLE_COUNT_EN to add m2_cycles/m1_cycles run-length outputs.
module sram_decode_sequencer
   import sram_seq_pkg::*;
#(
   parameter int ADDR_W        = 18,
   parameter int DATA_W        = 16,
   parameter int UART_TIMEOUT  = UART_TIMEOUT_DEF,
   parameter int STAGE_TIMEOUT = STAGE_TIMEOUT_DEF,
   parameter int TMR_W         = TMR_W_DEF
)(
   input  logic                CLOCK_50_I,
   input  logic                resetn,
   input  logic                uart_rx_i,
   input  logic [ADDR_W-1:0]   uart_addr,
   input  logic [DATA_W-1:0]   uart_wdata,
   input  logic                uart_we_n,
   input  logic [ADDR_W-1:0]   m2_addr,
   input  logic [DATA_W-1:0]   m2_wdata,
   input  logic                m2_we_n,
   input  logic                m2_done,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic                m1_we_n,
   input  logic                m1_done,
   input  logic [ADDR_W-1:0]   vga_addr,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic [DATA_W-1:0]   sram_wdata,
   output logic                sram_we_n,
   output logic                uart_init,
   output logic                uart_enable,
   output logic                m2_enable,
   output logic                m1_enable,
   output logic                vga_enable,
`ifdef STAGE_CYCLE_COUNT_EN
   output logic [31:0]         m2_cycles,
   output logic [31:0]         m1_cycles,
`endif
   output logic [2:0]          phase,
   output logic                error
);

   localparam logic [TMR_W-1:0] UART_LAST = TMR_W'(UART_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] STAGE_LIM = TMR_W'(STAGE_TIMEOUT);

   phase_t           st;
   logic [TMR_W-1:0] timer;

   assign phase = st;

   sram_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
      .phase      (st),
      .vga_addr   (vga_addr),
      .uart_addr  (uart_addr),
      .uart_wdata (uart_wdata),
      .uart_we_n  (uart_we_n),
      .m2_addr    (m2_addr),
      .m2_wdata   (m2_wdata),
      .m2_we_n    (m2_we_n),
      .m1_addr    (m1_addr),
      .m1_wdata   (m1_wdata),
      .m1_we_n    (m1_we_n),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_we_n  (sram_we_n)
   );

   // phase FSM with shared saturating timer; a done pulse beats the watchdog in the same cycle
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         st          <= IDLE;
         timer       <= '0;
         error       <= 1'b0;
         uart_init   <= 1'b0;
         uart_enable <= 1'b0;
         m2_enable   <= 1'b0;
         m1_enable   <= 1'b0;
         vga_enable  <= 1'b1;
      end else begin
         uart_init   <= 1'b0;
         uart_enable <= 1'b0;
         if (st != IDLE) timer <= timer == '1 ? timer : timer + 1'b1;
         case (st)
            IDLE: begin
               vga_enable <= 1'b1;
               if (!uart_rx_i) begin
                  st         <= UART_INIT;
                  timer      <= '0;
                  vga_enable <= 1'b0;
                  uart_init  <= 1'b1;
               end
            end
            UART_INIT: begin
               st          <= UART_RX;
               uart_enable <= 1'b1;
            end
            UART_RX: begin
               if (!uart_we_n) timer <= '0;
               else if (timer == UART_LAST) begin
                  st    <= M2_RUN;
                  timer <= '0;
               end
            end
            M2_RUN: begin
               if (m2_done) begin
                  st        <= M2_DRAIN;
                  m2_enable <= 1'b0;
               end else if (timer == STAGE_LIM) begin
                  st         <= IDLE;
                  error      <= 1'b1;
                  m2_enable  <= 1'b0;
                  vga_enable <= 1'b1;
               end else m2_enable <= 1'b1;
            end
            M2_DRAIN: begin
               st    <= M1_RUN;
               timer <= '0;
            end
            M1_RUN: begin
               if (m1_done) begin
                  st        <= M1_DRAIN;
                  m1_enable <= 1'b0;
               end else if (timer == STAGE_LIM) begin
                  st         <= IDLE;
                  error      <= 1'b1;
                  m1_enable  <= 1'b0;
                  vga_enable <= 1'b1;
               end else m1_enable <= 1'b1;
            end
            M1_DRAIN: begin
               st         <= IDLE;
               vga_enable <= 1'b1;
            end
            default: begin
               st         <= IDLE;
               m2_enable  <= 1'b0;
               m1_enable  <= 1'b0;
               vga_enable <= 1'b1;
            end
         endcase
      end
   end

`ifdef STAGE_CYCLE_COUNT_EN
   logic [31:0] m2_run_cnt, m1_run_cnt;

   // run counters restart outside RUN; outputs clear on the first RUN cycle and latch the inclusive length at done
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         m2_run_cnt <= '0;
         m1_run_cnt <= '0;
         m2_cycles  <= '0;
         m1_cycles  <= '0;
      end else begin
         m2_run_cnt <= st == M2_RUN ? m2_run_cnt + 32'd1 : '0;
         m1_run_cnt <= st == M1_RUN ? m1_run_cnt + 32'd1 : '0;
         m2_cycles  <= st == M2_RUN && m2_done ? m2_run_cnt + 32'd1 : st == M2_RUN && m2_run_cnt == '0 ? '0 : m2_cycles;
         m1_cycles  <= st == M1_RUN && m1_done ? m1_run_cnt + 32'd1 : st == M1_RUN && m1_run_cnt == '0 ? '0 : m1_cycles;
      end
   end
`endif

endmodule

// File: tb/tb_sram_decode_sequencer.sv
// tb_sram_decode_sequencer: randomized self-checking bench for the decode sequencer
module tb_sram_decode_sequencer;

   localparam int AW = 18;
   localparam int DW = 16;
   localparam logic [2:0] P_IDLE = 3'd0, P_INIT = 3'd1, P_RX = 3'd2, P_M2 = 3'd3, P_M2D = 3'd4, P_M1 = 3'd5, P_M1D = 3'd6;

   logic          CLOCK_50_I = 1'b0;
   logic          resetn = 1'b0;
   logic          uart_rx_i = 1'b1;
   logic [AW-1:0] uart_addr = '0, m2_addr = '0, m1_addr = '0, vga_addr = '0;
   logic [DW-1:0] uart_wdata = '0, m2_wdata = '0, m1_wdata = '0;
   logic          uart_we_n = 1'b1, m2_we_n = 1'b1, m1_we_n = 1'b1;
   logic          m2_done = 1'b0, m1_done = 1'b0;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata;
   logic          sram_we_n, uart_init, uart_enable, m2_enable, m1_enable, vga_enable, error;
   logic [2:0]    phase;

   int n_chk = 0;
   int n_fail = 0;

   always #10 CLOCK_50_I = ~CLOCK_50_I;

   sram_decode_sequencer #(.ADDR_W(AW), .DATA_W(DW), .UART_TIMEOUT(100), .STAGE_TIMEOUT(500), .TMR_W(26)) dut (
      .CLOCK_50_I (CLOCK_50_I), .resetn (resetn), .uart_rx_i (uart_rx_i),
      .uart_addr (uart_addr), .uart_wdata (uart_wdata), .uart_we_n (uart_we_n),
      .m2_addr (m2_addr), .m2_wdata (m2_wdata), .m2_we_n (m2_we_n), .m2_done (m2_done),
      .m1_addr (m1_addr), .m1_wdata (m1_wdata), .m1_we_n (m1_we_n), .m1_done (m1_done),
      .vga_addr (vga_addr),
      .sram_addr (sram_addr), .sram_wdata (sram_wdata), .sram_we_n (sram_we_n),
      .uart_init (uart_init), .uart_enable (uart_enable),
      .m2_enable (m2_enable), .m1_enable (m1_enable), .vga_enable (vga_enable),
      .phase (phase), .error (error)
   );

   // reference grant table: who owns the port in a given phase
   function automatic logic [AW-1:0] mdl_addr(input logic [2:0] ph);
      case (ph)
         P_IDLE:        return vga_addr;
         P_INIT, P_RX:  return uart_addr;
         P_M2, P_M2D:   return m2_addr;
         P_M1, P_M1D:   return m1_addr;
         default:       return '0;
      endcase
   endfunction

   function automatic logic [DW-1:0] mdl_wdata(input logic [2:0] ph);
      case (ph)
         P_INIT, P_RX:  return uart_wdata;
         P_M2, P_M2D:   return m2_wdata;
         P_M1, P_M1D:   return m1_wdata;
         default:       return '0;
      endcase
   endfunction

   function automatic logic mdl_we_n(input logic [2:0] ph);
      case (ph)
         P_INIT, P_RX:  return uart_we_n;
         P_M2, P_M2D:   return m2_we_n;
         P_M1, P_M1D:   return m1_we_n;
         default:       return 1'b1;
      endcase
   endfunction

   task automatic tick();
      @(posedge CLOCK_50_I);
      #1;
   endtask

   task automatic idle_reqs();
      uart_we_n = 1'b1;
      m2_we_n   = 1'b1;
      m1_we_n   = 1'b1;
      m2_done   = 1'b0;
      m1_done   = 1'b0;
   endtask

   task automatic randomize_reqs();
      uart_addr  = AW'($urandom);
      uart_wdata = DW'($urandom);
      uart_we_n  = 1'($urandom);
      m2_addr    = AW'($urandom);
      m2_wdata   = DW'($urandom);
      m2_we_n    = 1'($urandom);
      m1_addr    = AW'($urandom);
      m1_wdata   = DW'($urandom);
      m1_we_n    = 1'($urandom);
      vga_addr   = AW'($urandom);
   endtask

   // start bit, one UART write, then wait for the load timeout; lat = cycles from write to M2_RUN
   task automatic go_m2(output int lat);
      idle_reqs();
      uart_rx_i = 1'b0;
      tick();
      uart_rx_i = 1'b1;
      tick();
      uart_addr = AW'($urandom);
      uart_we_n = 1'b0;
      tick();
      uart_we_n = 1'b1;
      lat = 0;
      while (phase !== P_M2 && lat < 400) begin
         tick();
         lat++;
      end
   endtask

   // finish M2 immediately and step into M1_RUN with m1_enable raised
   task automatic go_m1();
      m2_done = 1'b1;
      tick();
      m2_done = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      idle_reqs();
      resetn = 1'b0;
      repeat (3) tick();
      resetn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         randomize_reqs();
         #1;
         n_chk++;
         if ({phase, vga_enable, uart_init, uart_enable, m2_enable, m1_enable, error} !== {P_IDLE, 6'b100000}) begin
            n_fail++;
            $display("FAIL reset_state: got phase=%0d vga=%b init=%b en=%b m2e=%b m1e=%b err=%b, want phase=0 vga=1 rest=0",
                     phase, vga_enable, uart_init, uart_enable, m2_enable, m1_enable, error);
         end
         n_chk++;
         if ({sram_addr, sram_wdata, sram_we_n} !== {mdl_addr(P_IDLE), mdl_wdata(P_IDLE), mdl_we_n(P_IDLE)}) begin
            n_fail++;
            $display("FAIL idle_grant: got addr=%h wd=%h we_n=%b, want addr=%h wd=%h we_n=%b",
                     sram_addr, sram_wdata, sram_we_n, mdl_addr(P_IDLE), mdl_wdata(P_IDLE), mdl_we_n(P_IDLE));
         end
         tick();
      end
      idle_reqs();
   endtask

   task automatic test_uart_load();
      int ip, ep, n;
      ip = 0;
      ep = 0;
      idle_reqs();
      uart_rx_i = 1'b0;
      tick();
      uart_rx_i = 1'b1;
      ip += int'(uart_init);
      ep += int'(uart_enable);
      n_chk++;
      if (phase !== P_INIT || vga_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL start_bit: got phase=%0d vga=%b, want phase=%0d vga=0", phase, vga_enable, P_INIT);
      end
      tick();
      ip += int'(uart_init);
      ep += int'(uart_enable);
      n_chk++;
      if (phase !== P_RX) begin
         n_fail++;
         $display("FAIL uart_rx_entry: got phase=%0d want %0d", phase, P_RX);
      end
      for (int k = 0; k < 3; k++) begin
         repeat (39) begin
            tick();
            ip += int'(uart_init);
            ep += int'(uart_enable);
         end
         uart_addr  = AW'(k);
         uart_wdata = DW'($urandom);
         uart_we_n  = 1'b0;
         m2_addr    = AW'($urandom);
         m2_we_n    = 1'b0;
         #1;
         n_chk++;
         if ({sram_addr, sram_wdata, sram_we_n} !== {AW'(k), uart_wdata, 1'b0}) begin
            n_fail++;
            $display("FAIL uart_write%0d: got addr=%h wd=%h we_n=%b, want addr=%h wd=%h we_n=0", k, sram_addr, sram_wdata, sram_we_n, k, uart_wdata);
         end
         tick();
         ip += int'(uart_init);
         ep += int'(uart_enable);
         uart_we_n = 1'b1;
         m2_we_n   = 1'b1;
      end
      n = 0;
      while (phase !== P_M2 && n < 300) begin
         tick();
         ip += int'(uart_init);
         ep += int'(uart_enable);
         n++;
      end
      n_chk++;
      if (n !== 100) begin
         n_fail++;
         $display("FAIL uart_timeout: M2_RUN after %0d cycles, want 100", n);
      end
      n_chk++;
      if (ip !== 1 || ep !== 1) begin
         n_fail++;
         $display("FAIL uart_strobes: got init pulses=%0d enable pulses=%0d, want 1 and 1", ip, ep);
      end
   endtask

   task automatic test_m2();
      int t;
      t = 0;
      n_chk++;
      if (m2_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL m2_enable_entry: got %b want 0", m2_enable);
      end
      m2_addr   = AW'(18'h01234);
      m2_wdata  = DW'($urandom);
      m2_we_n   = 1'b0;
      m1_addr   = AW'(18'h00042);
      m1_we_n   = 1'b0;
      uart_addr = AW'($urandom);
      uart_we_n = 1'b0;
      #1;
      n_chk++;
      if ({sram_addr, sram_wdata, sram_we_n} !== {18'h01234, m2_wdata, 1'b0}) begin
         n_fail++;
         $display("FAIL m2_grant: got addr=%h wd=%h we_n=%b, want addr=01234 wd=%h we_n=0", sram_addr, sram_wdata, sram_we_n, m2_wdata);
      end
      for (int i = 0; i < 8; i++) begin
         randomize_reqs();
         uart_rx_i = 1'($urandom);
         m1_done   = 1'($urandom);
         #1;
         n_chk++;
         if ({sram_addr, sram_wdata, sram_we_n} !== {mdl_addr(P_M2), mdl_wdata(P_M2), mdl_we_n(P_M2)}) begin
            n_fail++;
            $display("FAIL m2_rand_grant: got addr=%h wd=%h we_n=%b, want addr=%h wd=%h we_n=%b",
                     sram_addr, sram_wdata, sram_we_n, mdl_addr(P_M2), mdl_wdata(P_M2), mdl_we_n(P_M2));
         end
         tick();
         t++;
         n_chk++;
         if (phase !== P_M2 || m2_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL m2_hold: got phase=%0d m2_enable=%b, want phase=%0d m2_enable=1", phase, m2_enable, P_M2);
         end
      end
      uart_rx_i = 1'b1;
      idle_reqs();
      repeat (500 - t) tick();
      m2_done  = 1'b1;
      m2_addr  = AW'(76800);
      m2_wdata = DW'($urandom);
      m2_we_n  = 1'b0;
      #1;
      n_chk++;
      if ({sram_addr, sram_wdata, sram_we_n} !== {AW'(76800), m2_wdata, 1'b0}) begin
         n_fail++;
         $display("FAIL done_write: got addr=%h wd=%h we_n=%b, want addr=%h wd=%h we_n=0", sram_addr, sram_wdata, sram_we_n, AW'(76800), m2_wdata);
      end
      tick();
      m2_done = 1'b0;
      m2_we_n = 1'b1;
      n_chk++;
      if ({phase, m2_enable, m1_enable, error} !== {P_M2D, 3'b000}) begin
         n_fail++;
         $display("FAIL m2_drain: got phase=%0d m2e=%b m1e=%b err=%b, want phase=%0d 0 0 0 (done beats watchdog)", phase, m2_enable, m1_enable, error, P_M2D);
      end
      m2_addr = AW'($urandom);
      #1;
      n_chk++;
      if (sram_addr !== m2_addr) begin
         n_fail++;
         $display("FAIL drain_grant: got addr=%h want %h", sram_addr, m2_addr);
      end
      tick();
      n_chk++;
      if (phase !== P_M1 || m1_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL m1_entry: got phase=%0d m1_enable=%b, want phase=%0d m1_enable=0", phase, m1_enable, P_M1);
      end
      tick();
      n_chk++;
      if (m1_enable !== 1'b1) begin
         n_fail++;
         $display("FAIL m1_enable_rise: got %b want 1", m1_enable);
      end
   endtask

   task automatic test_watchdog();
      int t;
      t = 1;
      while (phase === P_M1 && t < 700) begin
         randomize_reqs();
         m2_done = 1'($urandom);
         #1;
         n_chk++;
         if ({sram_addr, sram_wdata, sram_we_n, error} !== {mdl_addr(P_M1), mdl_wdata(P_M1), mdl_we_n(P_M1), 1'b0}) begin
            n_fail++;
            $display("FAIL m1_run_grant: got addr=%h wd=%h we_n=%b err=%b, want addr=%h wd=%h we_n=%b err=0",
                     sram_addr, sram_wdata, sram_we_n, error, mdl_addr(P_M1), mdl_wdata(P_M1), mdl_we_n(P_M1));
         end
         tick();
         t++;
      end
      idle_reqs();
      n_chk++;
      if (t !== 501) begin
         n_fail++;
         $display("FAIL watchdog_time: left M1_RUN after %0d cycles, want 501", t);
      end
      n_chk++;
      if ({phase, error, vga_enable, m1_enable, m2_enable} !== {P_IDLE, 4'b1100}) begin
         n_fail++;
         $display("FAIL watchdog_state: got phase=%0d err=%b vga=%b m1e=%b m2e=%b, want phase=0 err=1 vga=1 m1e=0 m2e=0",
                  phase, error, vga_enable, m1_enable, m2_enable);
      end
   endtask

   task automatic test_rerun();
      int lat;
      repeat (5) tick();
      go_m2(lat);
      n_chk++;
      if (lat !== 100 || error !== 1'b1) begin
         n_fail++;
         $display("FAIL rerun_load: got latency=%0d err=%b, want 100 and 1", lat, error);
      end
      go_m1();
      n_chk++;
      if (phase !== P_M1 || m1_enable !== 1'b1) begin
         n_fail++;
         $display("FAIL rerun_m1: got phase=%0d m1_enable=%b, want %0d and 1", phase, m1_enable, P_M1);
      end
      m1_done = 1'b1;
      tick();
      m1_done = 1'b0;
      n_chk++;
      if (phase !== P_M1D || m1_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL m1_drain: got phase=%0d m1_enable=%b, want %0d and 0", phase, m1_enable, P_M1D);
      end
      tick();
      n_chk++;
      if ({phase, vga_enable, error} !== {P_IDLE, 2'b11}) begin
         n_fail++;
         $display("FAIL rerun_end: got phase=%0d vga=%b err=%b, want phase=0 vga=1 err=1 (sticky)", phase, vga_enable, error);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      go_m2(lat);
      go_m1();
      n_chk++;
      if (lat !== 100 || phase !== P_M1 || m1_enable !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset: got latency=%0d phase=%0d m1e=%b, want 100 %0d 1", lat, phase, m1_enable, P_M1);
      end
      m1_we_n = 1'b0;
      resetn  = 1'b0;
      #1;
      n_chk++;
      if ({m1_enable, phase, error, vga_enable, sram_we_n} !== {1'b0, P_IDLE, 3'b011}) begin
         n_fail++;
         $display("FAIL async_reset: got m1e=%b phase=%0d err=%b vga=%b we_n=%b, want 0 0 0 1 1",
                  m1_enable, phase, error, vga_enable, sram_we_n);
      end
      tick();
      resetn  = 1'b1;
      m1_we_n = 1'b1;
      tick();
      n_chk++;
      if (phase !== P_IDLE || error !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset: got phase=%0d err=%b, want 0 0", phase, error);
      end
   endtask

   initial begin
      test_reset();
      test_uart_load();
      test_m2();
      test_watchdog();
      test_rerun();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
